// File: rtl/video_timing_gen_mm.sv
// Multi-mode raster timing generator (three run-time selectable modes).
// Mode changes and stop requests are applied only at a frame boundary.
module video_timing_gen_mm #(
    parameter int unsigned            CNT_W  = 12,
    parameter logic [4*CNT_W-1:0]     M0_H   = {CNT_W'(640),  CNT_W'(16),  CNT_W'(96), CNT_W'(48)},
    parameter logic [4*CNT_W-1:0]     M0_V   = {CNT_W'(480),  CNT_W'(10),  CNT_W'(2),  CNT_W'(33)},
    parameter logic [1:0]             M0_POL = 2'b00,
    parameter logic [4*CNT_W-1:0]     M1_H   = {CNT_W'(1280), CNT_W'(110), CNT_W'(40), CNT_W'(220)},
    parameter logic [4*CNT_W-1:0]     M1_V   = {CNT_W'(720),  CNT_W'(5),   CNT_W'(5),  CNT_W'(20)},
    parameter logic [1:0]             M1_POL = 2'b11,
    parameter logic [4*CNT_W-1:0]     M2_H   = {CNT_W'(1920), CNT_W'(88),  CNT_W'(44), CNT_W'(148)},
    parameter logic [4*CNT_W-1:0]     M2_V   = {CNT_W'(1080), CNT_W'(4),   CNT_W'(5),  CNT_W'(36)},
    parameter logic [1:0]             M2_POL = 2'b11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       mode_sel,
    input  logic             mode_req,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic [1:0]       mode_cur,
    output logic             mode_err
);

    localparam int unsigned TW = 4 * CNT_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state, nxt_state;
    logic [1:0]       pending, nxt_mode;
    logic [CNT_W-1:0] nxt_x, nxt_y;

    // Timing table lookup; field order is {active, front_porch, sync_width, back_porch}.
    function automatic logic [TW-1:0] sel_h(input logic [1:0] m);
        case (m)
            2'd1:    return M1_H;
            2'd2:    return M2_H;
            default: return M0_H;
        endcase
    endfunction

    function automatic logic [TW-1:0] sel_v(input logic [1:0] m);
        case (m)
            2'd1:    return M1_V;
            2'd2:    return M2_V;
            default: return M0_V;
        endcase
    endfunction

    function automatic logic [1:0] sel_pol(input logic [1:0] m);
        case (m)
            2'd1:    return M1_POL;
            2'd2:    return M2_POL;
            default: return M0_POL;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] total(input logic [TW-1:0] t);
        return t[3*CNT_W +: CNT_W] + t[2*CNT_W +: CNT_W] + t[CNT_W +: CNT_W] + t[0 +: CNT_W];
    endfunction

    // Counter wrap points for the mode currently being generated.
    logic [TW-1:0]    cur_h, cur_v;
    logic [CNT_W-1:0] h_last, v_last;
    logic             last_x, last_y, boundary;

    always_comb begin
        cur_h    = sel_h(mode_cur);
        cur_v    = sel_v(mode_cur);
        h_last   = total(cur_h) - CNT_W'(1);
        v_last   = total(cur_v) - CNT_W'(1);
        last_x   = (x == h_last);
        last_y   = (y == v_last);
        boundary = last_x && last_y;
    end

    // Next-state, next counters and next mode.
    always_comb begin
        nxt_state = state;
        nxt_x     = x;
        nxt_y     = y;
        nxt_mode  = mode_cur;
        case (state)
            IDLE: begin
                nxt_x = '0;
                nxt_y = '0;
                if (enable) begin
                    nxt_state = RUN;
                    nxt_mode  = pending;
                end
            end
            RUN, DRAIN: begin
                if (last_x) begin
                    nxt_x = '0;
                    nxt_y = last_y ? '0 : y + CNT_W'(1);
                end else begin
                    nxt_x = x + CNT_W'(1);
                end
                if (boundary) nxt_mode = pending;
                if (state == RUN) begin
                    if (!enable) nxt_state = DRAIN;
                end else if (enable) begin
                    nxt_state = RUN;
                end else if (boundary) begin
                    nxt_state = IDLE;
                    nxt_x     = '0;
                    nxt_y     = '0;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Decode the next x/y against the next mode so registered outputs stay aligned.
    logic [TW-1:0]    nh, nv;
    logic [1:0]       npol;
    logic [CNT_W-1:0] n_ha, n_va, hs_beg, hs_end, vs_beg, vs_end;
    logic             nxt_run, nxt_de, nxt_hs, nxt_vs;

    always_comb begin
        nh      = sel_h(nxt_mode);
        nv      = sel_v(nxt_mode);
        npol    = sel_pol(nxt_mode);
        n_ha    = nh[3*CNT_W +: CNT_W];
        n_va    = nv[3*CNT_W +: CNT_W];
        hs_beg  = n_ha + nh[2*CNT_W +: CNT_W];
        hs_end  = hs_beg + nh[CNT_W +: CNT_W];
        vs_beg  = n_va + nv[2*CNT_W +: CNT_W];
        vs_end  = vs_beg + nv[CNT_W +: CNT_W];
        nxt_run = (nxt_state != IDLE);
        nxt_de  = nxt_run && (nxt_x < n_ha) && (nxt_y < n_va);
        nxt_hs  = nxt_run && (nxt_x >= hs_beg) && (nxt_x < hs_end);
        nxt_vs  = nxt_run && (nxt_y >= vs_beg) && (nxt_y < vs_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            hsync       <= ~M0_POL[1];
            vsync       <= ~M0_POL[0];
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            mode_cur    <= 2'd0;
            pending     <= 2'd0;
            mode_err    <= 1'b0;
        end else begin
            x           <= nxt_x;
            y           <= nxt_y;
            de          <= nxt_de;
            hsync       <= nxt_hs ? npol[1] : ~npol[1];
            vsync       <= nxt_vs ? npol[0] : ~npol[0];
            line_start  <= nxt_run && (nxt_x == '0);
            frame_start <= nxt_run && (nxt_x == '0) && (nxt_y == '0);
            mode_cur    <= nxt_mode;
            mode_err    <= mode_req && (mode_sel == 2'd3);
            if (mode_req && (mode_sel != 2'd3)) pending <= mode_sel;
        end
    end

endmodule
